// File: rtl/dac_pkg.sv
// dac_pkg: shared types and widths for the DAC sample path.
package dac_pkg;
  typedef enum logic {PRIMING, STREAMING} fifo_state_e;
  localparam int DAC_DATA_W = 16;
  localparam int DAC_UNDERRUN_CNT_W = 16;
endpackage

// File: rtl/dac_fifo_ram.sv
// dac_fifo_ram: DEPTH x 16 sample storage, synchronous write, asynchronous read.
module dac_fifo_ram
  import dac_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       mclk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DAC_DATA_W-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DAC_DATA_W-1:0]      rdata
);
  logic [DAC_DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge mclk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: priming elastic buffer ahead of the AD5541A driver.
// Define DAC_FIFO_UNDERRUN_CNT_EN to add a saturating underrun_cnt output.
module dac_sample_fifo
  import dac_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PREFILL = 4
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          s_axis_valid,
  output logic                          s_axis_ready,
  input  logic [DAC_DATA_W-1:0]         s_axis_data,
  output logic                          m_axis_valid,
  input  logic                          m_axis_ready,
  output logic [DAC_DATA_W-1:0]         m_axis_data,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          underrun
`ifdef DAC_FIFO_UNDERRUN_CNT_EN
  ,
  output logic [DAC_UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DAC_DATA_W-1:0] rd_data, hold;
  fifo_state_e state, state_nxt;
  logic push, pop, empty, full;
  assign full         = level == LW'(DEPTH);
  assign empty        = level == '0;
  assign s_axis_ready = en && !full;
  assign m_axis_valid = state == STREAMING && !empty;
  assign push         = s_axis_valid && s_axis_ready;
  assign pop          = en && m_axis_valid && m_axis_ready;
  // Once drained, keep presenting the last head sample rather than stale RAM
  assign m_axis_data  = empty ? hold : rd_data;
  dac_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .mclk  (mclk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (s_axis_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );
  always_comb begin
    state_nxt = !en ? PRIMING
              : state == PRIMING ? (level >= LW'(PREFILL) ? STREAMING : PRIMING)
              : (pop && !push && level == LW'(1)) ? PRIMING : STREAMING;
  end
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      state    <= PRIMING;
      underrun <= 1'b0;
      hold     <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      level    <= level + LW'(push) - LW'(pop);
      state    <= state_nxt;
      underrun <= en && m_axis_ready && !m_axis_valid;
      if (!empty) hold <= rd_data;
    end
  end
`ifdef DAC_FIFO_UNDERRUN_CNT_EN
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) underrun_cnt <= '0;
    else if (underrun && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_dac_sample_fifo.sv
// tb_dac_sample_fifo: randomized scoreboard bench against a queue-based reference model.
module tb_dac_sample_fifo;
  localparam int DEPTH = 16;
  localparam int PREFILL = 4;
  logic mclk = 0, rst = 1, en = 0;
  logic s_axis_valid = 0, m_axis_ready = 0;
  logic [15:0] s_axis_data = 0;
  logic s_axis_ready, m_axis_valid, underrun;
  logic [15:0] m_axis_data;
  logic [4:0] level;
`ifdef DAC_FIFO_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
  int exp_cnt;
`endif
  int tests = 0, fails = 0;
  logic [15:0] exp_q[$];
  bit primed, exp_und;
  logic [15:0] last;

  dac_sample_fifo #(.DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
    .mclk         (mclk),
    .rst          (rst),
    .en           (en),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_data  (s_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_data  (m_axis_data),
    .level        (level),
    .underrun     (underrun)
`ifdef DAC_FIFO_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the FIFO is a queue; output is only offered once primed.
  always @(posedge mclk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      primed = 0;
      exp_und = 0;
      last = 0;
`ifdef DAC_FIFO_UNDERRUN_CNT_EN
      exp_cnt = 0;
`endif
    end else begin
      int n;
      bit pu, po, ov;
      n = exp_q.size();
      ov = primed && n > 0;
      pu = en && s_axis_valid && n < DEPTH;
      po = en && m_axis_ready && ov;
`ifdef DAC_FIFO_UNDERRUN_CNT_EN
      if (exp_und && exp_cnt < 16'hFFFF) exp_cnt++;
`endif
      exp_und = en && m_axis_ready && !ov;
      if (n > 0) last = exp_q[0];
      if (po) void'(exp_q.pop_front());
      if (pu) exp_q.push_back(s_axis_data);
      if (!en) primed = 0;
      else if (!primed) primed = n >= PREFILL;
      else if (po && !pu && n == 1) primed = 0;
    end
  end

  // Monitor: compares status every cycle and the head sample on each handshake.
  always @(negedge mclk) begin
    if (!rst) begin
      int n;
      n = exp_q.size();
      chk("s_axis_ready", s_axis_ready, en && n < DEPTH);
      chk("m_axis_valid", m_axis_valid, primed && n > 0);
      chk("level", level, n);
      chk("underrun", underrun, exp_und);
      if (m_axis_valid && m_axis_ready && en && n > 0) chk("pop_data", m_axis_data, exp_q[0]);
      else chk("head_data", m_axis_data, n > 0 ? exp_q[0] : last);
`ifdef DAC_FIFO_UNDERRUN_CNT_EN
      chk("underrun_cnt", underrun_cnt, exp_cnt);
`endif
    end
  end

  task automatic cyc(input int k = 1);
    repeat (k) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] d);
    s_axis_valid = 1;
    s_axis_data = d;
    cyc();
    s_axis_valid = 0;
  endtask

  initial begin
    cyc(3);
    en = 1;
    rst = 0;
    cyc(3);
    for (int i = 1; i <= 4; i++) push(16'(i) << 12);
    cyc(3);
    for (int i = 0; i < 14; i++) push(16'($urandom));
    m_axis_ready = 1;
    s_axis_valid = 1;
    cyc();
    m_axis_ready = 0;
    cyc();
    s_axis_valid = 0;
    for (int i = 0; i < 11; i++) begin
      m_axis_ready = 1;
      cyc();
      m_axis_ready = 0;
      cyc(2);
    end
    for (int i = 0; i < 40; i++) begin
      s_axis_valid = 1;
      m_axis_ready = 1;
      s_axis_data = 16'($urandom);
      cyc();
    end
    s_axis_valid = 0;
    m_axis_ready = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(99);
      m_axis_ready = 1;
      cyc();
      m_axis_ready = 0;
    end
    cyc(3);
    for (int i = 0; i < 7; i++) push(16'($urandom));
    cyc(2);
    chk("level_pre_rst", level, 7);
    @(posedge mclk);
    #3 rst = 1;
    #1;
    chk("rst_level", level, 0);
    chk("rst_valid", m_axis_valid, 0);
    cyc(2);
    rst = 0;
    for (int i = 0; i < 6; i++) push(16'($urandom));
    en = 0;
    for (int i = 0; i < 20; i++) begin
      s_axis_valid = 1'($urandom);
      m_axis_ready = 1'($urandom);
      s_axis_data = 16'($urandom);
      cyc();
    end
    chk("en_low_level", level, 6);
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 29) != 0;
      s_axis_valid = $urandom_range(0, 2) != 0;
      m_axis_ready = $urandom_range(0, 3) == 0;
      s_axis_data = 16'($urandom);
      cyc();
    end
    s_axis_valid = 0;
    m_axis_ready = 0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
